// File: rtl/axi_alwr_pkg.sv
// Shared types and constants for the AXI write to AL write bridge.
// Holds the bridge FSM state enum, AXI burst-type and response encodings,
// and a helper that recognises the burst lengths a WRAP burst may use.
package axi_alwr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // A wrapping window must hold 2, 4, 8 or 16 beats.
    function automatic logic wrap_len_legal(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Next word-address generator for one AXI burst beat.
// Ports:
//   addr      - current word address
//   burst     - AXI burst type (FIXED/INCR/WRAP; reserved holds)
//   len       - AXI awlen of the burst, used as the WRAP window mask
//   addr_next - word address of the following beat
// The WRAP term is always computed; whether WRAP bursts are honoured at all
// is decided in the parent, which drops every beat of an unsupported burst.
module axi_burst_addr_gen
    import axi_alwr_pkg::*;
#(
    parameter int WA = 10
) (
    input  logic [WA-1:0] addr,
    input  logic [1:0]    burst,
    input  logic [7:0]    len,
    output logic [WA-1:0] addr_next
);

    logic [WA-1:0] addr_inc;
    logic [WA-1:0] wrap_mask;

    assign addr_inc  = addr + 1'b1;
    // For legal wrap lengths (2^n - 1) awlen is exactly the in-window offset mask.
    assign wrap_mask = WA'(len);

    always_comb begin
        addr_next = addr;
        case (burst)
            BURST_INCR: addr_next = addr_inc;
            BURST_WRAP: addr_next = (addr & ~wrap_mask) | (addr_inc & wrap_mask);
            default:    addr_next = addr;
        endcase
    end

endmodule

// File: rtl/axi_wr_to_alwr.sv
// AXI4 slave write channel (AW/W/B) to AL word-addressed write channel bridge.
// One burst in flight at a time; beats with partial strobes are consumed and
// dropped, and the burst then completes with SLVERR.
// Ports:
//   clk, rst         - clock, synchronous active-high reset
//   s_axi_aw*        - AXI write address channel (id, addr, len, burst)
//   s_axi_w*         - AXI write data channel
//   s_axi_b*         - AXI write response channel
//   m_al_w*          - AL write channel (word address, data, valid/ready)
// Build option: define AXI_WR_TO_ALWR_WRAP_EN to accept WRAP bursts.
//
// State   | meaning
// IDLE    | awready high, waiting for an AW handshake
// DATA    | passing / dropping W beats until the counter reaches zero
// RESP    | presenting the B response until bready
module axi_wr_to_alwr
    import axi_alwr_pkg::*;
#(
    parameter int DATA_BITS  = 2,
    parameter int DATA_WIDTH = 8 << DATA_BITS,
    parameter int ADDR_WIDTH = 12,
    parameter int ID_WIDTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [ID_WIDTH-1:0]           s_axi_awid,
    input  logic [ADDR_WIDTH-1:0]         s_axi_awaddr,
    input  logic [7:0]                    s_axi_awlen,
    input  logic [1:0]                    s_axi_awburst,
    input  logic                          s_axi_awvalid,
    output logic                          s_axi_awready,
    input  logic [DATA_WIDTH-1:0]         s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0]       s_axi_wstrb,
    input  logic                          s_axi_wlast,
    input  logic                          s_axi_wvalid,
    output logic                          s_axi_wready,
    output logic [ID_WIDTH-1:0]           s_axi_bid,
    output logic [1:0]                    s_axi_bresp,
    output logic                          s_axi_bvalid,
    input  logic                          s_axi_bready,
    output logic [ADDR_WIDTH-1:DATA_BITS] m_al_waddr,
    output logic [DATA_WIDTH-1:0]         m_al_wdata,
    output logic                          m_al_wvalid,
    input  logic                          m_al_wready
);

    localparam int WA = ADDR_WIDTH - DATA_BITS;

    state_t              state_q;
    logic [ID_WIDTH-1:0] id_q;
    logic [WA-1:0]       addr_q;
    logic [WA-1:0]       addr_nxt;
    logic [7:0]          cnt_q;
    logic [7:0]          len_q;
    logic [1:0]          burst_q;
    logic                err_q;

    logic burst_ok;
    logic beat_good;
    logic in_data;
    logic aw_fire;
    logic w_fire;
    logic b_fire;
    logic wlast_bad;

    axi_burst_addr_gen #(.WA(WA)) u_addr_gen (
        .addr      (addr_q),
        .burst     (burst_q),
        .len       (len_q),
        .addr_next (addr_nxt)
    );

    always_comb begin
        burst_ok = 1'b0;
        case (burst_q)
            BURST_FIXED: burst_ok = 1'b1;
            BURST_INCR:  burst_ok = 1'b1;
`ifdef AXI_WR_TO_ALWR_WRAP_EN
            // An illegal wrap length is handled like an unsupported burst.
            BURST_WRAP:  burst_ok = wrap_len_legal(len_q);
`else
            BURST_WRAP:  burst_ok = 1'b0;
`endif
            default:     burst_ok = 1'b0;
        endcase
    end

    assign beat_good = (&s_axi_wstrb) && burst_ok;
    // Outputs are gated by rst directly so they are quiet during the reset
    // cycle itself, before the state register has been cleared.
    assign in_data   = (state_q == ST_DATA) && !rst;

    assign s_axi_awready = (state_q == ST_IDLE) && !rst;
    assign s_axi_wready  = in_data && (beat_good ? m_al_wready : 1'b1);
    assign m_al_wvalid   = in_data && beat_good && s_axi_wvalid;
    assign m_al_wdata    = s_axi_wdata;
    assign m_al_waddr    = rst ? '0 : addr_q;

    assign s_axi_bvalid  = (state_q == ST_RESP) && !rst;
    assign s_axi_bid     = s_axi_bvalid ? id_q : '0;
    assign s_axi_bresp   = (s_axi_bvalid && err_q) ? RESP_SLVERR : RESP_OKAY;

    assign aw_fire   = s_axi_awvalid && s_axi_awready;
    assign w_fire    = s_axi_wvalid && s_axi_wready;
    assign b_fire    = s_axi_bvalid && s_axi_bready;
    assign wlast_bad = s_axi_wlast != (cnt_q == 8'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            id_q    <= '0;
            addr_q  <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            burst_q <= BURST_FIXED;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (aw_fire) begin
                        id_q    <= s_axi_awid;
                        addr_q  <= s_axi_awaddr[ADDR_WIDTH-1:DATA_BITS];
                        cnt_q   <= s_axi_awlen;
                        len_q   <= s_axi_awlen;
                        burst_q <= s_axi_awburst;
                        err_q   <= 1'b0;
                        state_q <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_fire) begin
                        addr_q <= addr_nxt;
                        cnt_q  <= cnt_q - 8'd1;
                        if (!beat_good || wlast_bad) begin
                            err_q <= 1'b1;
                        end
                        if (cnt_q == 8'd0) begin
                            state_q <= ST_RESP;
                        end
                    end
                end
                ST_RESP: begin
                    if (b_fire) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_wr_to_alwr.sv
module tb_axi_wr_to_alwr;

    localparam int DB = 2;
    localparam int DW = 32;
    localparam int AW = 12;
    localparam int IW = 4;
    localparam int WA = AW - DB;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [IW-1:0] s_axi_awid = '0;
    logic [AW-1:0] s_axi_awaddr = '0;
    logic [7:0]    s_axi_awlen = '0;
    logic [1:0]    s_axi_awburst = '0;
    logic          s_axi_awvalid = 1'b0;
    logic          s_axi_awready;
    logic [DW-1:0] s_axi_wdata = '0;
    logic [3:0]    s_axi_wstrb = '0;
    logic          s_axi_wlast = 1'b0;
    logic          s_axi_wvalid = 1'b0;
    logic          s_axi_wready;
    logic [IW-1:0] s_axi_bid;
    logic [1:0]    s_axi_bresp;
    logic          s_axi_bvalid;
    logic          s_axi_bready = 1'b0;
    logic [AW-1:DB] m_al_waddr;
    logic [DW-1:0] m_al_wdata;
    logic          m_al_wvalid;
    logic          m_al_wready = 1'b0;

    always #5 clk = ~clk;

    axi_wr_to_alwr #(.DATA_BITS(DB), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW)) dut (
        .clk(clk), .rst(rst),
        .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
        .s_axi_awburst(s_axi_awburst), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready),
        .m_al_waddr(m_al_waddr), .m_al_wdata(m_al_wdata), .m_al_wvalid(m_al_wvalid),
        .m_al_wready(m_al_wready)
    );

    typedef struct {
        logic [WA-1:0] a;
        logic [DW-1:0] d;
    } beat_t;

    int checks = 0;
    int errors = 0;

    beat_t         exp_q[$];
    beat_t         got_q[$];
    logic [DW-1:0] wd[$];
    logic [3:0]    ws[$];
    bit            wl[$];
    bit            exp_err;
    int            data_cycles;

    function automatic bit supported(input logic [1:0] b, input int len);
        if (b == 2'b00 || b == 2'b01) return 1'b1;
`ifdef AXI_WR_TO_ALWR_WRAP_EN
        if (b == 2'b10 && (len == 1 || len == 3 || len == 7 || len == 15)) return 1'b1;
`endif
        return 1'b0;
    endfunction

    // Fill per-beat stimulus: random data, full strobes except at bad_idx,
    // wlast only at last_idx.
    function automatic void prep_beats(input int len, input int bad_idx,
                                       input logic [3:0] bad_strb, input int last_idx);
        wd.delete(); ws.delete(); wl.delete();
        for (int k = 0; k <= len; k++) begin
            wd.push_back($urandom);
            ws.push_back(k == bad_idx ? bad_strb : 4'hF);
            wl.push_back(k == last_idx);
        end
    endfunction

    // Reference: which beats reach AL, at which word address, and the response.
    function automatic void build_expect(input logic [AW-1:0] addr, input int len,
                                         input logic [1:0] b);
        int    w;
        int    n;
        int    base;
        int    a;
        bit    ok;
        beat_t bt;
        w    = int'(addr) / (1 << DB);
        n    = len + 1;
        base = (w / n) * n;
        ok   = supported(b, len);
        exp_q.delete();
        exp_err = !ok;
        for (int k = 0; k <= len; k++) begin
            if (b == 2'b00)      a = w;
            else if (b == 2'b01) a = (w + k) % (1 << WA);
            else                 a = base + ((w - base + k) % n);
            if (ws[k] != 4'hF) exp_err = 1'b1;
            else if (ok) begin
                bt.a = a[WA-1:0];
                bt.d = wd[k];
                exp_q.push_back(bt);
            end
            if (wl[k] != (k == len)) exp_err = 1'b1;
        end
    endfunction

    // rmode: 0 = always ready, 1 = AL ready toggles, 2 = random valid/ready
    task automatic do_burst(input logic [IW-1:0] id, input logic [AW-1:0] addr,
                            input int len, input logic [1:0] b, input int rmode,
                            input string name);
        int    guard;
        int    k;
        int    cyc;
        int    hold;
        beat_t g;
        build_expect(addr, len, b);
        got_q.delete();
        @(negedge clk);
        s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = 8'(len);
        s_axi_awburst = b; s_axi_awvalid = 1'b1;
        #1;
        guard = 0;
        while (!s_axi_awready && guard < 50) begin
            @(negedge clk); #1; guard++;
        end
        checks++;
        if (guard >= 50) begin
            errors++;
            $display("FAIL %s aw_timeout awready=%0b required=1", name, s_axi_awready);
        end
        @(negedge clk);
        s_axi_awvalid = 1'b0;
        k = 0; cyc = 0;
        while (k <= len && cyc < 300) begin
            s_axi_wvalid = (rmode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
            s_axi_wdata  = wd[k];
            s_axi_wstrb  = ws[k];
            s_axi_wlast  = wl[k];
            m_al_wready  = (rmode == 0) ? 1'b1 : (rmode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
            #1;
            if (m_al_wvalid && m_al_wready) begin
                g.a = m_al_waddr;
                g.d = m_al_wdata;
                got_q.push_back(g);
            end
            if (s_axi_wvalid && s_axi_wready) k++;
            cyc++;
            @(negedge clk);
        end
        data_cycles = cyc;
        s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0; m_al_wready = 1'b0;
        checks++;
        if (k <= len) begin
            errors++;
            $display("FAIL %s w_timeout beats=%0d required=%0d", name, k, len + 1);
        end
        #1;
        checks++;
        if (s_axi_bvalid !== 1'b1) begin
            errors++;
            $display("FAIL %s bvalid_after_last got=%0b required=1", name, s_axi_bvalid);
        end
        hold = $urandom_range(0, 2);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk); #1;
            checks++;
            if (s_axi_bvalid !== 1'b1) begin
                errors++;
                $display("FAIL %s bvalid_hold got=%0b required=1", name, s_axi_bvalid);
            end
        end
        s_axi_bready = 1'b1;
        #1;
        checks++;
        if (s_axi_bid !== id) begin
            errors++;
            $display("FAIL %s bid got=%0h required=%0h", name, s_axi_bid, id);
        end
        checks++;
        if (s_axi_bresp !== (exp_err ? 2'b10 : 2'b00)) begin
            errors++;
            $display("FAIL %s bresp got=%0b required=%0b", name, s_axi_bresp, exp_err ? 2'b10 : 2'b00);
        end
        @(negedge clk);
        s_axi_bready = 1'b0;
        #1;
        checks++;
        if (s_axi_bvalid !== 1'b0 || s_axi_awready !== 1'b1) begin
            errors++;
            $display("FAIL %s after_b bvalid=%0b awready=%0b required 0/1", name, s_axi_bvalid, s_axi_awready);
        end
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL %s al_beat_count got=%0d required=%0d", name, got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (got_q[i].a !== exp_q[i].a || got_q[i].d !== exp_q[i].d) begin
                    errors++;
                    $display("FAIL %s al_beat%0d got=%0h/%0h required=%0h/%0h", name, i,
                             got_q[i].a, got_q[i].d, exp_q[i].a, exp_q[i].d);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_wstrb = 4'hF;
        m_al_wready = 1'b1; s_axi_bready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({s_axi_awready, s_axi_wready, s_axi_bvalid, m_al_wvalid} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_handshakes got=%b required=0000",
                     {s_axi_awready, s_axi_wready, s_axi_bvalid, m_al_wvalid});
        end
        checks++;
        if (s_axi_bresp !== 2'b00 || s_axi_bid !== '0 || m_al_waddr !== '0) begin
            errors++;
            $display("FAIL reset_values bresp=%0b bid=%0h waddr=%0h required all 0",
                     s_axi_bresp, s_axi_bid, m_al_waddr);
        end
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; m_al_wready = 1'b0; s_axi_bready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (s_axi_awready !== 1'b1 || s_axi_wready !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle awready=%0b wready=%0b required 1/0", s_axi_awready, s_axi_wready);
        end
    endtask

    task automatic test_incr();
        prep_beats(3, -1, 4'hF, 3);
        do_burst(4'h5, 12'h010, 3, 2'b01, 0, "incr");
        checks++;
        if (data_cycles != 4) begin
            errors++;
            $display("FAIL incr_latency cycles=%0d required=4", data_cycles);
        end
        checks++;
        if (got_q.size() != 4 || got_q[0].a !== 10'd4 || got_q[3].a !== 10'd7) begin
            errors++;
            $display("FAIL incr_addrs count=%0d required 4 beats at 4..7", got_q.size());
        end
    endtask

    task automatic test_fixed();
        prep_beats(2, -1, 4'hF, 2);
        do_burst(4'hA, 12'h020, 2, 2'b00, 1, "fixed");
    endtask

    task automatic test_bad_strobe();
        prep_beats(1, 0, 4'hE, 1);
        do_burst(4'h3, 12'h100, 1, 2'b01, 0, "bad_strobe");
    endtask

    task automatic test_wlast_early();
        prep_beats(2, -1, 4'hF, 1);
        do_burst(4'h7, 12'h040, 2, 2'b01, 0, "wlast_early");
    endtask

    task automatic test_wrap();
        prep_beats(3, -1, 4'hF, 3);
        do_burst(4'h9, 12'h018, 3, 2'b10, 0, "wrap");
    endtask

    task automatic test_incr_wraparound();
        prep_beats(2, -1, 4'hF, 2);
        do_burst(4'h1, 12'hFFC, 2, 2'b01, 2, "incr_wrap_top");
    endtask

    task automatic test_mid_reset();
        int k;
        @(negedge clk);
        s_axi_awid = 4'h6; s_axi_awaddr = 12'h080; s_axi_awlen = 8'd3;
        s_axi_awburst = 2'b01; s_axi_awvalid = 1'b1;
        @(negedge clk);
        s_axi_awvalid = 1'b0;
        k = 0;
        for (int c = 0; c < 10 && k < 2; c++) begin
            s_axi_wvalid = 1'b1; s_axi_wdata = $urandom; s_axi_wstrb = 4'hF;
            s_axi_wlast = 1'b0; m_al_wready = 1'b1;
            #1;
            if (s_axi_wvalid && s_axi_wready) k++;
            @(negedge clk);
        end
        rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++;
            if (m_al_wvalid !== 1'b0 || s_axi_bvalid !== 1'b0) begin
                errors++;
                $display("FAIL mid_reset_quiet wvalid=%0b bvalid=%0b required 0/0", m_al_wvalid, s_axi_bvalid);
            end
            @(negedge clk);
        end
        rst = 1'b0;
        s_axi_wvalid = 1'b0; m_al_wready = 1'b0;
        #1;
        checks++;
        if (s_axi_awready !== 1'b1 || s_axi_bvalid !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_resume awready=%0b bvalid=%0b required 1/0", s_axi_awready, s_axi_bvalid);
        end
        prep_beats(1, -1, 4'hF, 1);
        do_burst(4'h2, 12'h0C4, 1, 2'b01, 0, "after_reset");
    endtask

    task automatic test_random();
        int          len;
        logic [1:0]  b;
        logic [AW-1:0] addr;
        int          bad;
        int          last;
        for (int t = 0; t < 25; t++) begin
            b    = 2'($urandom_range(0, 3));
            len  = ($urandom_range(0, 1) == 1) ? (2 ** $urandom_range(1, 4)) - 1 : $urandom_range(0, 9);
            addr = 12'($urandom);
            bad  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len) : -1;
            last = ($urandom_range(0, 5) == 0) ? $urandom_range(0, len) : len;
            prep_beats(len, bad, 4'($urandom_range(0, 14)), last);
            do_burst(4'($urandom), addr, len, b, 2, "random");
        end
    endtask

    initial begin
        test_reset();
        test_incr();
        test_fixed();
        test_bad_strobe();
        test_wlast_early();
        test_wrap();
        test_incr_wraparound();
        test_mid_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
